// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared FSM encoding and default parameter values for the
// serial burst slave (serial_slave_burst_if) and its field receiver.
package serial_bus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 12;
    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned LEN_WIDTH_DEF   = 4;
    localparam int unsigned SPLIT_DELAY_DEF = 4;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;

    // Fixed encodings so state values stay identical to the legacy design.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        WDATA = 3'd3,
        WMEM  = 3'd4,
        RMEM  = 3'd5,
        SPLIT = 3'd6,
        RBUS  = 3'd7
    } state_e;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_rx.sv
// serial_shift_rx: LSB-first serial field receiver.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en_i       - a valid serial bit is present this cycle
//   bit_i      - serial bit
//   data_o     - assembled field (complete the cycle after done_o)
//   done_o     - the bit accepted this cycle is the last of the field
module serial_shift_rx
    import serial_bus_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             done_o
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] data_q;

    assign done_o = en_i && (cnt_q == CW'(WIDTH - 1));
    assign data_o = data_q;

    // New bits enter at the MSB so the first bit ends up at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else if (en_i) begin
            data_q <= {bit_i, data_q[WIDTH-1:1]};
            cnt_q  <= done_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/serial_slave_burst_if.sv
// serial_slave_burst_if: serial-bus burst slave bridging a bit-serial master
// to a parallel memory port. Header = address (ADDR_WIDTH bits), length
// (LEN_WIDTH bits, beats = LEN+1), all fields LSB first; writes then carry
// DATA_WIDTH bits per beat, reads return DATA_WIDTH bits per beat.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   bwdata, bmode, bwvalid        - serial write bit, 1=write/0=read, bit valid
//   split_grant                   - arbiter grant to resume a split read
//   brdata, brvalid, berr         - serial read bit, valid, timeout-substitute flag
//   sready, ssplit                - idle/accepting, bus split in progress
//   mem_addr, mem_ren, mem_wen, mem_wvalid, mem_wdata - memory request
//   mem_rdata, mem_rvalid         - memory read return
// Configuration: define SERIAL_SLAVE_SPLIT_EN to enable split reads on the
// first read beat; otherwise ssplit is tied low and split_grant is unused.
module serial_slave_burst_if
    import serial_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int unsigned SPLIT_DELAY = SPLIT_DELAY_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bwdata,
    input  logic                  bmode,
    input  logic                  bwvalid,
    input  logic                  split_grant,
    output logic                  brdata,
    output logic                  brvalid,
    output logic                  berr,
    output logic                  sready,
    output logic                  ssplit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic                  mem_wvalid,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int unsigned TW = cnt_width(MEM_TIMEOUT);
    localparam int unsigned BW = cnt_width(DATA_WIDTH);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [BW-1:0]         rb_q, rb_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] addr_data;
    logic [LEN_WIDTH-1:0]  len_data;
    logic [DATA_WIDTH-1:0] wd_data;
    logic                  addr_done, len_done, wd_done;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  last_beat;

    // Address bit 0 is accepted in IDLE together with bmode.
    serial_shift_rx #(.WIDTH(ADDR_WIDTH)) u_addr_rx (
        .clk(clk), .rst(rst),
        .en_i(bwvalid && (state_q == IDLE || state_q == ADDR)),
        .bit_i(bwdata), .data_o(addr_data), .done_o(addr_done)
    );

    serial_shift_rx #(.WIDTH(LEN_WIDTH)) u_len_rx (
        .clk(clk), .rst(rst),
        .en_i(bwvalid && state_q == LEN),
        .bit_i(bwdata), .data_o(len_data), .done_o(len_done)
    );

    serial_shift_rx #(.WIDTH(DATA_WIDTH)) u_wdata_rx (
        .clk(clk), .rst(rst),
        .en_i(bwvalid && state_q == WDATA),
        .bit_i(bwdata), .data_o(wd_data), .done_o(wd_done)
    );

    // Truncating add gives the all-ones -> zero address wrap.
    assign beat_addr = addr_data + ADDR_WIDTH'(beat_q);
    assign last_beat = (beat_q == len_data);

`ifdef SERIAL_SLAVE_SPLIT_EN
    localparam int unsigned SW = cnt_width(SPLIT_DELAY + 1);
    logic [SW-1:0] split_q, split_d;
`else
    logic        unused_split_grant;
    logic [31:0] unused_split_delay;
    assign unused_split_grant = split_grant;
    assign unused_split_delay = 32'(SPLIT_DELAY);
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        err_d   = err_q;
`ifdef SERIAL_SLAVE_SPLIT_EN
        // Split window counts down from read start, independent of the FSM.
        split_d = (split_q != '0) ? split_q - SW'(1) : split_q;
`endif
        case (state_q)
            IDLE: begin
                beat_d = '0;
                err_d  = 1'b0;
                if (bwvalid) begin
                    mode_d  = bmode;
                    state_d = addr_done ? LEN : ADDR;
                end
            end
            ADDR: if (addr_done) state_d = LEN;
            LEN: begin
                if (len_done) begin
                    if (mode_q) begin
                        state_d = WDATA;
                    end else begin
                        state_d = RMEM;
                        tmo_d   = '0;
`ifdef SERIAL_SLAVE_SPLIT_EN
                        split_d = SW'(SPLIT_DELAY);
`endif
                    end
                end
            end
            WDATA: if (wd_done) state_d = WMEM;
            WMEM: begin
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    beat_d  = beat_q + LEN_WIDTH'(1);
                    state_d = WDATA;
                end
            end
            RMEM: begin
                if (mem_rvalid || tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                    // Timeout substitutes all-ones data and flags the beat.
                    rd_d  = mem_rvalid ? mem_rdata : '1;
                    err_d = !mem_rvalid;
                    tmo_d = '0;
                    rb_d  = '0;
`ifdef SERIAL_SLAVE_SPLIT_EN
                    state_d = (beat_q == '0) ? SPLIT : RBUS;
`else
                    state_d = RBUS;
`endif
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SPLIT: begin
`ifdef SERIAL_SLAVE_SPLIT_EN
                if (split_q == '0 && split_grant) state_d = RBUS;
`else
                state_d = IDLE;
`endif
            end
            RBUS: begin
                rd_d = rd_q >> 1;
                rb_d = rb_q + BW'(1);
                if (rb_q == BW'(DATA_WIDTH - 1)) begin
                    err_d = 1'b0;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + LEN_WIDTH'(1);
                        state_d = RMEM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            beat_q  <= '0;
            tmo_q   <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef SERIAL_SLAVE_SPLIT_EN
            split_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef SERIAL_SLAVE_SPLIT_EN
            split_q <= split_d;
`endif
        end
    end

    assign sready     = (state_q == IDLE);
    assign mem_ren    = (state_q == RMEM);
    assign mem_wen    = (state_q == WMEM);
    assign mem_wvalid = (state_q == WMEM);
    assign mem_addr   = (state_q == RMEM || state_q == WMEM) ? beat_addr : '0;
    assign mem_wdata  = (state_q == WMEM) ? wd_data : '0;
    assign brvalid    = (state_q == RBUS);
    assign brdata     = (state_q == RBUS) && rd_q[0];
    assign berr       = (state_q == RBUS) && err_q;
`ifdef SERIAL_SLAVE_SPLIT_EN
    assign ssplit     = (split_q != '0);
`else
    assign ssplit     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_slave_burst_if.sv
module tb_serial_slave_burst_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bwdata = 1'b0, bmode = 1'b0, bwvalid = 1'b0, split_grant = 1'b0;
    logic        brdata, brvalid, berr, sready, ssplit;
    logic [11:0] mem_addr;
    logic        mem_ren, mem_wen, mem_wvalid;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_rvalid = 1'b0;

    serial_slave_burst_if #(
        .ADDR_WIDTH(12), .DATA_WIDTH(8), .LEN_WIDTH(4),
        .SPLIT_DELAY(4), .MEM_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .bwdata(bwdata), .bmode(bmode), .bwvalid(bwvalid),
        .split_grant(split_grant), .brdata(brdata), .brvalid(brvalid), .berr(berr),
        .sready(sready), .ssplit(ssplit), .mem_addr(mem_addr), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [7:0]  mem_model [0:4095];
    int          rd_lat = -1;
    int          ren_run = 0;
    logic [20:0] wr_exp[$], wr_obs[$];
    logic [1:0]  rb_exp[$], rb_obs[$];
    int          run_obs[$];
    int          runlen = 0;
    int          ren_cyc = 0, wen_cyc = 0, ssplit_cyc = 0, first_brv_cyc = -1;

    always @(posedge clk) cyc++;

    // Memory responder: answers a read request after rd_lat waiting cycles.
    always @(posedge clk) begin
        #1;
        mem_rvalid = 1'b0;
        if (mem_ren && rd_lat >= 0) begin
            if (ren_run == rd_lat) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_model[mem_addr];
                ren_run    = 0;
            end else begin
                ren_run++;
            end
        end else begin
            ren_run = 0;
        end
    end

    // Monitor: collects DUT activity into observed queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wen) begin
                wr_obs.push_back({mem_wvalid, mem_addr, mem_wdata});
                wen_cyc++;
            end
            if (mem_ren) ren_cyc++;
            if (ssplit) ssplit_cyc++;
            if (brvalid) begin
                rb_obs.push_back({berr, brdata});
                runlen++;
                if (first_brv_cyc < 0) first_brv_cyc = cyc;
            end else if (runlen != 0) begin
                run_obs.push_back(runlen);
                runlen = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        wr_exp.delete(); wr_obs.delete(); rb_exp.delete(); rb_obs.delete();
        run_obs.delete();
        ren_cyc = 0; wen_cyc = 0; ssplit_cyc = 0; first_brv_cyc = -1;
    endtask

    task automatic drive_bit(input logic b, input logic v);
        @(posedge clk); #1;
        bwvalid = v;
        bwdata  = b;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sready === 1'b1) begin seen = 1; break; end
        end
        #1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_idle: sready=%b required 1 within 300 cycles", name, sready);
        end
    endtask

    task automatic send_header(input logic mode, input logic [11:0] a,
                               input logic [3:0] len, input bit gap);
        bmode = mode;
        for (int i = 0; i < 12; i++) begin
            drive_bit(a[i], 1'b1);
            if (i == 1) begin
                @(negedge clk);
                checks++;
                if (sready !== 1'b0) begin
                    errors++;
                    $display("FAIL sready_drop: sready=%b required 0", sready);
                end
            end
            if (gap && i == 5) begin
                drive_bit(1'b1, 1'b0);
                drive_bit(1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_bit(len[i], 1'b1);
            if (gap && i == 1) drive_bit(1'b1, 1'b0);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] len,
                            input logic [7:0] d0, input bit gap);
        logic [7:0]  dat;
        logic [11:0] ak;
        send_header(1'b1, a, len, gap);
        for (int k = 0; k <= int'(len); k++) begin
            dat = d0 + 8'(k);
            ak  = a + 12'(k);
            wr_exp.push_back({1'b1, ak, dat});
            for (int b = 0; b < 8; b++) drive_bit(dat[b], 1'b1);
            drive_bit(1'b0, 1'b0);
        end
        wait_idle("write");
    endtask

    task automatic push_read(input logic [7:0] dat, input logic e);
        for (int b = 0; b < 8; b++) rb_exp.push_back({e, dat[b]});
    endtask

    task automatic check_writes(input string name);
        logic [20:0] e, o;
        checks++;
        if (wr_obs.size() != wr_exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes required %0d", name, wr_obs.size(), wr_exp.size());
        end
        while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
            e = wr_exp.pop_front();
            o = wr_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s_beat: got wv/addr/data %h required %h", name, o, e);
            end
        end
        checks++;
        if (ren_cyc != 0) begin
            errors++;
            $display("FAIL %s_no_ren: mem_ren cycles %0d required 0", name, ren_cyc);
        end
    endtask

    task automatic check_reads(input string name, input int beats, input int exp_ren,
                               input int exp_split);
        logic [1:0] e, o;
        int r;
        checks++;
        if (rb_obs.size() != rb_exp.size()) begin
            errors++;
            $display("FAIL %s_bits: got %0d bits required %0d", name, rb_obs.size(), rb_exp.size());
        end
        while (rb_exp.size() > 0 && rb_obs.size() > 0) begin
            e = rb_exp.pop_front();
            o = rb_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s_bit: got berr/brdata %b required %b", name, o, e);
            end
        end
        checks++;
        if (run_obs.size() != beats) begin
            errors++;
            $display("FAIL %s_bursts: got %0d bursts required %0d", name, run_obs.size(), beats);
        end
        while (run_obs.size() > 0) begin
            r = run_obs.pop_front();
            checks++;
            if (r != 8) begin
                errors++;
                $display("FAIL %s_burst_len: got %0d required 8", name, r);
            end
        end
        checks++;
        if (ren_cyc != exp_ren) begin
            errors++;
            $display("FAIL %s_ren_cycles: got %0d required %0d", name, ren_cyc, exp_ren);
        end
        checks++;
        if (wen_cyc != 0) begin
            errors++;
            $display("FAIL %s_no_wen: got %0d required 0", name, wen_cyc);
        end
        checks++;
        if (ssplit_cyc != exp_split) begin
            errors++;
            $display("FAIL %s_ssplit: got %0d cycles required %0d", name, ssplit_cyc, exp_split);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sready, brdata, brvalid, berr, ssplit, mem_ren, mem_wen, mem_wvalid} !== 8'b1000_0000
            || mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got sready..wvalid=%b addr=%h wdata=%h required 10000000 000 00",
                     {sready, brdata, brvalid, berr, ssplit, mem_ren, mem_wen, mem_wvalid},
                     mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_single();
        clear_sb();
        do_write(12'h0A5, 4'd0, 8'h3C, 1'b0);
        check_writes("write_single");
    endtask

    task automatic test_write_wrap();
        clear_sb();
        do_write(12'hFFE, 4'd3, 8'h01, 1'b1);
        check_writes("write_wrap");
    endtask

    task automatic test_read_burst();
        clear_sb();
        mem_model[12'h010] = 8'h81;
        mem_model[12'h011] = 8'h7E;
        push_read(8'h81, 1'b0);
        push_read(8'h7E, 1'b0);
        rd_lat = 2;
        send_header(1'b0, 12'h010, 4'd1, 1'b0);
        drive_bit(1'b0, 1'b0);
        wait_idle("read_burst");
        check_reads("read_burst", 2, 6, 0);
    endtask

    task automatic test_timeout();
        clear_sb();
        push_read(8'hFF, 1'b1);
        rd_lat = -1;
        send_header(1'b0, 12'h200, 4'd0, 1'b0);
        drive_bit(1'b0, 1'b0);
        wait_idle("timeout");
        check_reads("timeout", 1, 16, 0);
    endtask

    task automatic test_reset_midwrite();
        clear_sb();
        send_header(1'b1, 12'h055, 4'd0, 1'b0);
        for (int b = 0; b < 4; b++) drive_bit(1'b1, 1'b1);
        @(posedge clk); #1;
        bwvalid = 1'b1; bwdata = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        bwvalid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sready !== 1'b1 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: sready=%b mem_wen=%b required 1 0", sready, mem_wen);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (wen_cyc != 0) begin
            errors++;
            $display("FAIL midreset_no_write: got %0d writes required 0", wen_cyc);
        end
        do_write(12'h321, 4'd0, 8'h5A, 1'b0);
        check_writes("midreset_next");
    endtask

    task automatic test_back_to_back();
        clear_sb();
        do_write(12'h123, 4'd1, 8'hA0, 1'b0);
        check_writes("b2b_write");
        clear_sb();
        push_read(8'hA0, 1'b0);
        push_read(8'hA1, 1'b0);
        rd_lat = 0;
        send_header(1'b0, 12'h123, 4'd1, 1'b0);
        drive_bit(1'b0, 1'b0);
        wait_idle("b2b_read");
        check_reads("b2b_read", 2, 2, 0);
    endtask

`ifdef SERIAL_SLAVE_SPLIT_EN
    task automatic test_split();
        int gcyc;
        clear_sb();
        mem_model[12'h040] = 8'hC3;
        push_read(8'hC3, 1'b0);
        rd_lat = 2;
        split_grant = 1'b0;
        send_header(1'b0, 12'h040, 4'd0, 1'b0);
        drive_bit(1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        split_grant = 1'b1;
        gcyc = cyc;
        wait_idle("split");
        split_grant = 1'b0;
        check_reads("split", 1, 3, 4);
        checks++;
        if (first_brv_cyc != gcyc + 1) begin
            errors++;
            $display("FAIL split_resume: first brvalid cycle %0d required %0d", first_brv_cyc, gcyc + 1);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 8'h00;
        test_reset();
        test_write_single();
        test_write_wrap();
        test_read_burst();
        test_timeout();
        test_reset_midwrite();
        test_back_to_back();
`ifdef SERIAL_SLAVE_SPLIT_EN
        test_split();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Writes land in the bench memory so later reads can see them.
    always @(negedge clk) begin
        if (!rst && mem_wen) mem_model[mem_addr] = mem_wdata;
    end

endmodule
